// File: rtl/kernel_rd_seq.sv
// Kernel RAM read sequencer: walks a ring of layer slots, optionally repeating
// each layer block, gated by how many layers the producer has finished writing.
module kernel_rd_seq #(
   parameter int ADDR_W     = 11,
   parameter int SLOT_SHIFT = 9,
   parameter int SLOTS      = 4,
   parameter int WRD_W      = 6,
   parameter int KER_W      = 6,
   parameter int REP_W      = 8,
   parameter int CNT_W      = 7,
   parameter int RD_LAT     = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              repeat_en_i,
   input  logic [WRD_W-1:0]  words_per_ker_i,
   input  logic [KER_W-1:0]  num_ker_i,
   input  logic [CNT_W-1:0]  num_layers_i,
   input  logic [REP_W-1:0]  rep_cnt_i,
   input  logic [CNT_W:0]    wr_lay_ready_no_i,
   input  logic              ker_req_i,
   output logic              ker_ready_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              rd_en_o,
   output logic              rd_valid_o,
   output logic              lay_done_o,
   output logic [CNT_W:0]    rd_lay_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              cfg_err_o
);

   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [WRD_W-1:0]    r_wpk;
   logic [WRD_W-1:0]    r_wcnt;
   logic [KER_W-1:0]    r_nker;
   logic [KER_W-1:0]    r_kcnt;
   logic [CNT_W-1:0]    r_nlay;
   logic [REP_W-1:0]    r_rep;
   logic [REP_W-1:0]    r_rcnt;
   logic                r_rep_en;
   logic [CNT_W:0]      r_lay_cnt;
   logic [SLOT_W-1:0]   r_slot;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_cfg_err;
   logic [RD_LAT-1:0]   r_vpipe;

   logic [63:0]         w_blk_size;
   logic                w_cfg_ok;
   logic                w_ready;
   logic                w_accept;
   logic                w_wrap_w;
   logic                w_wrap_k;
   logic                w_eob;
   logic                w_rep_again;
   logic                w_lay_end;
   logic                w_last;
   logic [SLOT_W-1:0]   w_slot_next;
   logic [ADDR_W-1:0]   w_slot_base;
   logic [ADDR_W-1:0]   w_slot_next_base;

   // A layer block must fit inside one slot, otherwise it would spill into the next layer.
   assign w_blk_size = (64'(num_ker_i) + 64'd1) * (64'(words_per_ker_i) + 64'd1);
   assign w_cfg_ok   = (w_blk_size <= (64'd1 << SLOT_SHIFT));

   assign w_ready     = (r_state == READ) && (r_lay_cnt < wr_lay_ready_no_i);
   assign w_accept    = ker_req_i && w_ready && !start_i;
   assign w_wrap_w    = (r_wcnt == r_wpk);
   assign w_wrap_k    = (r_kcnt == r_nker);
   assign w_eob       = w_accept && w_wrap_w && w_wrap_k;
   assign w_rep_again = w_eob && r_rep_en && (r_rcnt != r_rep);
   assign w_lay_end   = w_eob && !w_rep_again;
   assign w_last      = w_lay_end && (r_lay_cnt == {1'b0, r_nlay});

   assign w_slot_next      = (r_slot == SLOT_W'(SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
   assign w_slot_base      = ADDR_W'(r_slot) << SLOT_SHIFT;
   assign w_slot_next_base = ADDR_W'(w_slot_next) << SLOT_SHIFT;

   always_comb begin
      w_state_next = r_state;
      if (start_i) begin
         w_state_next = w_cfg_ok ? READ : IDLE;
      end else begin
         case (r_state)
            READ:    if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wpk     <= '0;
         r_nker    <= '0;
         r_nlay    <= '0;
         r_rep     <= '0;
         r_rep_en  <= 1'b0;
         r_wcnt    <= '0;
         r_kcnt    <= '0;
         r_rcnt    <= '0;
         r_lay_cnt <= '0;
         r_slot    <= '0;
         r_addr    <= '0;
         r_cfg_err <= 1'b0;
      end else if (start_i) begin
         r_cfg_err <= !w_cfg_ok;
         r_wcnt    <= '0;
         r_kcnt    <= '0;
         r_rcnt    <= '0;
         r_lay_cnt <= '0;
         r_slot    <= '0;
         r_addr    <= '0;
         if (w_cfg_ok) begin
            r_wpk    <= words_per_ker_i;
            r_nker   <= num_ker_i;
            r_nlay   <= num_layers_i;
            r_rep    <= rep_cnt_i;
            r_rep_en <= repeat_en_i;
         end
      end else if (w_accept) begin
         if (w_eob) begin
            r_wcnt <= '0;
            r_kcnt <= '0;
            if (w_rep_again) begin
               r_rcnt <= r_rcnt + REP_W'(1);
               r_addr <= w_slot_base;
            end else begin
               r_rcnt    <= '0;
               r_lay_cnt <= r_lay_cnt + (CNT_W+1)'(1);
               // The final layer leaves the address where it stopped.
               if (!w_last) begin
                  r_slot <= w_slot_next;
                  r_addr <= w_slot_next_base;
               end
            end
         end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_wrap_w) begin
               r_wcnt <= '0;
               r_kcnt <= r_kcnt + KER_W'(1);
            end else begin
               r_wcnt <= r_wcnt + WRD_W'(1);
            end
         end
      end
   end

   // Stage i holds the read enable issued i+1 cycles ago; a restart flushes it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_vpipe <= '0;
      end else if (start_i) begin
         r_vpipe <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
         r_vpipe[0] <= w_accept;
      end
   end

   assign ker_ready_o  = w_ready;
   assign rd_en_o      = w_accept;
   assign rd_addr_o    = r_addr;
   assign rd_valid_o   = r_vpipe[RD_LAT-1];
   assign lay_done_o   = w_lay_end;
   assign rd_lay_cnt_o = r_lay_cnt;
   assign busy_o       = (r_state == READ) || (|r_vpipe);
   assign done_o       = (r_state == DONE);
   assign cfg_err_o    = r_cfg_err;

endmodule

// File: doc/kernel_rd_seq.md
KERNEL_RD_SEQ -- requirements
Module: kernel_rd_seq

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- ADDR_W, 11, kernel RAM address width
- SLOT_SHIFT, 9, log2 words per layer slot
- SLOTS, 4, number of layer slots in RAM (ring); SLOTS<<SLOT_SHIFT <= 2^ADDR_W
- WRD_W, 6, word-count config width
- KER_W, 6, kernel-count config width
- REP_W, 8, repeat-count config width
- CNT_W, 7, layer-count width
- RD_LAT, 2, RAM read latency in cycles, >= 1
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock
- rst_n_i, in, 1, reset, asynchronous, active-low
- start_i, in, 1, one-cycle pulse; latches config, begins sequence
- repeat_en_i, in, 1, repeat each layer block rep_cnt_i+1 times
- words_per_ker_i, in, WRD_W, words per kernel minus 1
- num_ker_i, in, KER_W, kernels per layer minus 1
- num_layers_i, in, CNT_W, layers minus 1
- rep_cnt_i, in, REP_W, repeats minus 1
- wr_lay_ready_no_i, in, CNT_W+1, layers written by producer (monotonic)
- ker_req_i, in, 1, consumer requests one word
- ker_ready_o, out, 1, word may be accepted this cycle
- rd_addr_o, out, ADDR_W, RAM read address
- rd_en_o, out, 1, RAM read enable
- rd_valid_o, out, 1, RAM data valid
- lay_done_o, out, 1, pulse, last read of a layer accepted
- rd_lay_cnt_o, out, CNT_W+1, layers fully read
- busy_o, out, 1, sequence in progress
- done_o, out, 1, pulse, sequence complete
- cfg_err_o, out, 1, last start rejected

Function
REQ-003 FSM states SHALL be IDLE, READ, DONE; DONE lasts one cycle, then IDLE.
REQ-004 On start_i with (num_ker_i+1)*(words_per_ker_i+1) <= 2^SLOT_SHIFT, the module SHALL latch all config, clear counters, set rd_addr_o=0, cfg_err_o=0, enter READ next cycle.
REQ-005 On start_i with an oversized block, the module SHALL set cfg_err_o=1, go/stay IDLE, and leave counters cleared.
REQ-006 start_i SHALL have priority over any accept in the same cycle and SHALL restart from any state.
REQ-007 ker_ready_o SHALL equal (state==READ) && (rd_lay_cnt_o < wr_lay_ready_no_i), unsigned CNT_W+1-bit compare, combinational from registers.
REQ-008 An accept is ker_req_i && ker_ready_o; rd_en_o SHALL equal accept, same cycle, with rd_addr_o the current registered address.
REQ-009 ker_req_i without ker_ready_o SHALL be ignored; nothing advances.
REQ-010 rd_valid_o SHALL be rd_en_o delayed exactly RD_LAT cycles, cleared by start_i.
REQ-011 Each accept SHALL increment word counter; at words_per_ker wrap to 0 and increment kernel counter; at num_ker wrap = end of block.
REQ-012 On end of block with repeat_en latched and repeat counter != rep_cnt, the module SHALL increment repeat counter and reload rd_addr_o with current slot base.
REQ-013 Otherwise on end of block: repeat counter to 0, rd_lay_cnt_o +1, lay_done_o pulse, slot = (slot+1) mod SLOTS, rd_addr_o = slot<<SLOT_SHIFT; else rd_addr_o +1.
REQ-014 When end of block completes layer num_layers, the module SHALL enter DONE, pulse done_o, and hold rd_addr_o.
REQ-015 busy_o SHALL be 1 in READ and while any rd_valid_o pipeline stage is pending.
REQ-016 repeat_en=0 SHALL ignore rep_cnt_i (one pass per layer).

Reset
REQ-017 On rst_n_i low, asynchronously: state IDLE; all counters, rd_addr_o, ker_ready_o, rd_en_o, rd_valid_o pipeline, lay_done_o, done_o, busy_o, cfg_err_o = 0.
REQ-018 Reset mid-READ SHALL abandon the sequence; no done_o until a new start_i.

Verification
REQ-019 Defaults, words=1, ker=2, layers=1, repeat off, wr_lay_ready=2, req held -> addresses 0..5, 512..517, lay_done at 6th/12th accept, done_o next cycle, rd_valid_o 2 cycles after each rd_en_o.
REQ-020 repeat_en=1, rep_cnt=2, words=0, ker=1, layers=0 -> addresses 0,1,0,1,0,1; single lay_done_o; done_o.
REQ-021 wr_lay_ready=0 then 1 after 5 cycles, req held -> ker_ready_o low 5 cycles, layer 0 read, ker_ready_o drops while rd_lay_cnt_o=1 equals wr_lay_ready.
REQ-022 layers=5, SLOTS=4, words=0, ker=0 -> addresses 0,512,1024,1536,0,512 (slot wrap).
REQ-023 words=63, ker=63 (4096 > 512) -> cfg_err_o=1, state IDLE, ker_ready_o=0.
REQ-024 start_i coincident with accept mid-READ, then rst_n_i low mid-READ -> restart at address 0 with no rd_en_o; reset clears all outputs immediately, no done_o.
